// File: rtl/scope_stack_ctrl.sv
// scope_stack_ctrl: scope-ID stack that refuses duplicate (recursive) and over-depth pushes.
// A push scans every active level, one per cycle, before it is committed.
module scope_stack_ctrl #(
    parameter int ID_W  = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push_valid,
    input  logic [ID_W-1:0]            i_push_id,
    output logic                       o_push_ready,
    input  logic                       i_pop_valid,
    output logic                       o_pop_ready,
    input  logic                       i_clear_err,
    output logic                       o_resp_valid,
    output logic                       o_resp_ok,
    output logic [ID_W-1:0]            o_top_id,
    output logic [$clog2(DEPTH):0]     o_depth,
    output logic                       o_busy,
    output logic                       o_err_recursive,
    output logic                       o_err_overflow,
    output logic                       o_err_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_FULL = DW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_mem [DEPTH];
    logic [DW-1:0]      r_depth;
    logic [AW-1:0]      r_idx;
    logic [ID_W-1:0]    r_id;
    logic               r_match, r_ovf;
    logic               r_resp_valid, r_resp_ok;
    logic               r_err_recursive, r_err_overflow, r_err_underflow;
    logic               w_push_ready, w_pop_ready, w_push_go, w_pop_go;
    logic               w_hit, w_last, w_commit;
    logic [DW-1:0]      w_top;

    assign w_hit     = r_mem[r_idx] == r_id;
    assign w_last    = {1'b0, r_idx} == r_depth - D_ONE;
    assign w_push_go = w_push_ready & i_push_valid;
    assign w_pop_go  = w_pop_ready & i_pop_valid;
    assign w_commit  = r_state == S_RESP && !r_ovf && !r_match;
    assign w_top     = r_depth - D_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_push_ready = 1'b0;
        w_pop_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop_ready  = 1'b1;
                w_push_ready = ~i_pop_valid;
                if (i_push_valid && !i_pop_valid)
                    w_next = (r_depth == '0 || r_depth == D_FULL) ? S_RESP : S_SCAN;
            end
            S_SCAN:  w_next = (w_hit || w_last) ? S_RESP : S_SCAN;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Storage is deliberately not reset; only entries below depth are meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit)
            r_mem[r_depth[AW-1:0]] <= r_id;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_depth         <= '0;
            r_idx           <= '0;
            r_id            <= '0;
            r_match         <= 1'b0;
            r_ovf           <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_ok       <= 1'b0;
            r_err_recursive <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_resp_valid <= w_pop_go || r_state == S_RESP;
            r_resp_ok    <= (w_pop_go && r_depth != '0) || w_commit;
            if (w_pop_go && r_depth != '0)
                r_depth <= r_depth - D_ONE;
            if (w_push_go) begin
                r_id    <= i_push_id;
                r_idx   <= '0;
                r_ovf   <= r_depth == D_FULL;
                r_match <= 1'b0;
            end
            if (r_state == S_SCAN) begin
                if (w_hit)
                    r_match <= 1'b1;
                else if (!w_last)
                    r_idx <= r_idx + AW'(1);
            end
            if (w_commit)
                r_depth <= r_depth + D_ONE;
            // A flag being set in the same cycle as clear_err stays set.
            if (w_pop_go && r_depth == '0)
                r_err_underflow <= 1'b1;
            else if (i_clear_err)
                r_err_underflow <= 1'b0;
            if (r_state == S_RESP && r_ovf)
                r_err_overflow <= 1'b1;
            else if (i_clear_err)
                r_err_overflow <= 1'b0;
            if (r_state == S_RESP && !r_ovf && r_match)
                r_err_recursive <= 1'b1;
            else if (i_clear_err)
                r_err_recursive <= 1'b0;
        end
    end

    assign o_push_ready    = w_push_ready;
    assign o_pop_ready     = w_pop_ready;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_ok       = r_resp_ok;
    assign o_top_id        = (r_depth == '0) ? '0 : r_mem[w_top[AW-1:0]];
    assign o_depth         = r_depth;
    assign o_busy          = r_state == S_SCAN;
    assign o_err_recursive = r_err_recursive;
    assign o_err_overflow  = r_err_overflow;
    assign o_err_underflow = r_err_underflow;
endmodule

// File: tb/tb_scope_stack_ctrl.sv
// tb_scope_stack_ctrl: directed and random checks of scope_stack_ctrl against a queue-based model.
// Inputs are driven and outputs sampled on the falling edge; latency k means seen k falling edges after acceptance.
module tb_scope_stack_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_valid = 1'b0, pop_valid = 1'b0, clear_err = 1'b0;
    logic [3:0] push_id = '0;
    logic       push_ready, pop_ready, resp_valid, resp_ok, busy;
    logic       err_rec, err_ovf, err_und;
    logic [3:0] top_id;
    logic [3:0] depth;

    int checks = 0;
    int errors = 0;

    int  q[$];
    bit  m_rec, m_ovf, m_und;

    scope_stack_ctrl #(.ID_W(4), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_push_valid(push_valid), .i_push_id(push_id), .o_push_ready(push_ready),
        .i_pop_valid(pop_valid), .o_pop_ready(pop_ready), .i_clear_err(clear_err),
        .o_resp_valid(resp_valid), .o_resp_ok(resp_ok), .o_top_id(top_id), .o_depth(depth),
        .o_busy(busy), .o_err_recursive(err_rec), .o_err_overflow(err_ovf), .o_err_underflow(err_und)
    );

    always #5 clk = ~clk;

    function automatic int exp_push_lat(input int id);
        if (q.size() == 0 || q.size() == 8) return 2;
        foreach (q[k]) if (q[k] == id) return 3 + k;
        return 2 + q.size();
    endfunction

    function automatic bit model_push(input int id);
        if (q.size() == 8) begin m_ovf = 1; return 0; end
        foreach (q[k]) if (q[k] == id) begin m_rec = 1; return 0; end
        q.push_back(id);
        return 1;
    endfunction

    function automatic bit model_pop();
        if (q.size() == 0) begin m_und = 1; return 0; end
        void'(q.pop_back());
        return 1;
    endfunction

    function automatic int m_top();
        return q.size() == 0 ? 0 : q[q.size()-1];
    endfunction

    task automatic push_op(input int id, output int lat, output bit ok);
        push_id = 4'(id);
        push_valid = 1'b1;
        @(negedge clk);
        push_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!resp_valid) lat = -1;
        ok = resp_ok;
    endtask

    task automatic pop_op(output int lat, output bit ok);
        pop_valid = 1'b1;
        @(negedge clk);
        pop_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!resp_valid) lat = -1;
        ok = resp_ok;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push_valid = 1'b0; pop_valid = 1'b0; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete(); m_rec = 0; m_ovf = 0; m_und = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth); end
        checks++; if (top_id !== 4'd0) begin errors++; $display("FAIL reset_top got %0d exp 0", top_id); end
        checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_valid_busy got %b exp 00", {resp_valid, busy}); end
        checks++; if ({err_rec, err_ovf, err_und} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {err_rec, err_ovf, err_und}); end
        checks++; if ({push_ready, pop_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", {push_ready, pop_ready}); end
        pop_valid = 1'b1;
        #1;
        checks++; if ({push_ready, pop_ready} !== 2'b01) begin errors++; $display("FAIL reset_ready_popv got %b exp 01", {push_ready, pop_ready}); end
        pop_valid = 1'b0;
    endtask

    task automatic test_push_seq();
        int lat; bit ok;
        int ids[3] = '{3, 5, 9};
        int lats[3] = '{2, 3, 4};
        foreach (ids[i]) begin
            push_op(ids[i], lat, ok);
            void'(model_push(ids[i]));
            checks++; if (lat !== lats[i]) begin errors++; $display("FAIL seq_lat id=%0d got %0d exp %0d", ids[i], lat, lats[i]); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL seq_ok id=%0d got %b exp 1", ids[i], ok); end
        end
        checks++; if (depth !== 4'd3) begin errors++; $display("FAIL seq_depth got %0d exp 3", depth); end
        checks++; if (top_id !== 4'd9) begin errors++; $display("FAIL seq_top got %0d exp 9", top_id); end
    endtask

    task automatic test_recursion();
        int lat; bit ok;
        push_op(5, lat, ok);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rec_lat got %0d exp 4", lat); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL rec_ok got %b exp 0", ok); end
        checks++; if (err_rec !== 1'b1) begin errors++; $display("FAIL rec_flag got %b exp 1", err_rec); end
        checks++; if (depth !== 4'd3 || top_id !== 4'd9) begin errors++; $display("FAIL rec_stack got depth %0d top %0d exp 3 9", depth, top_id); end
    endtask

    task automatic test_overflow();
        int lat; bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) push_op(i, lat, ok);
        checks++; if (depth !== 4'd8 || top_id !== 4'd7) begin errors++; $display("FAIL fill got depth %0d top %0d exp 8 7", depth, top_id); end
        push_op(10, lat, ok);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ovf_lat got %0d exp 2", lat); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL ovf_ok got %b exp 0", ok); end
        checks++; if (err_ovf !== 1'b1 || err_rec !== 1'b0) begin errors++; $display("FAIL ovf_flags got ovf %b rec %b exp 1 0", err_ovf, err_rec); end
        checks++; if (depth !== 4'd8 || top_id !== 4'd7) begin errors++; $display("FAIL ovf_stack got depth %0d top %0d exp 8 7", depth, top_id); end
        for (int i = 7; i >= 0; i--) begin
            pop_op(lat, ok);
            checks++; if (lat !== 1 || ok !== 1'b1 || depth !== 4'(i)) begin errors++; $display("FAIL drain got lat %0d ok %b depth %0d exp 1 1 %0d", lat, ok, depth, i); end
        end
    endtask

    task automatic test_underflow_clear();
        int lat; bit ok;
        pop_op(lat, ok);
        checks++; if (lat !== 1 || ok !== 1'b0) begin errors++; $display("FAIL und_resp got lat %0d ok %b exp 1 0", lat, ok); end
        checks++; if (err_und !== 1'b1 || depth !== 4'd0) begin errors++; $display("FAIL und_state got flag %b depth %0d exp 1 0", err_und, depth); end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        checks++; if ({err_rec, err_ovf, err_und} !== 3'b000) begin errors++; $display("FAIL clear got %b exp 000", {err_rec, err_ovf, err_und}); end
        pop_valid = 1'b1; clear_err = 1'b1;
        @(negedge clk);
        pop_valid = 1'b0; clear_err = 1'b0;
        checks++; if (err_und !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b exp 1", err_und); end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic test_simultaneous();
        int lat; bit ok;
        do_reset();
        push_op(1, lat, ok); push_op(2, lat, ok);
        push_id = 4'd4; push_valid = 1'b1; pop_valid = 1'b1;
        #1;
        checks++; if ({push_ready, pop_ready} !== 2'b01) begin errors++; $display("FAIL sim_ready got %b exp 01", {push_ready, pop_ready}); end
        @(negedge clk);
        pop_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_ok !== 1'b1 || depth !== 4'd1) begin errors++; $display("FAIL sim_pop got v %b ok %b depth %0d exp 1 1 1", resp_valid, resp_ok, depth); end
        #1;
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL sim_push_ready got %b exp 1", push_ready); end
        @(negedge clk);
        push_valid = 1'b0;
        checks++; if (busy !== 1'b1 || push_ready !== 1'b0) begin errors++; $display("FAIL sim_scan got busy %b ready %b exp 1 0", busy, push_ready); end
        lat = 1;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 3 || resp_ok !== 1'b1) begin errors++; $display("FAIL sim_push got lat %0d ok %b exp 3 1", lat, resp_ok); end
        checks++; if (depth !== 4'd2 || top_id !== 4'd4) begin errors++; $display("FAIL sim_stack got depth %0d top %0d exp 2 4", depth, top_id); end
    endtask

    task automatic test_reset_mid_scan();
        int lat; bit ok; int seen;
        do_reset();
        for (int i = 10; i < 16; i++) push_op(i, lat, ok);
        push_id = 4'd0; push_valid = 1'b1;
        @(negedge clk);
        push_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (resp_valid !== 1'b0 || depth !== 4'd0 || busy !== 1'b0 || push_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got v %b depth %0d busy %b ready %b exp 0 0 0 1", resp_valid, depth, busy, push_ready); end
        seen = 0;
        repeat (10) begin @(negedge clk); seen += int'(resp_valid); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stray_resp got %0d exp 0", seen); end
        q.delete(); m_rec = 0; m_ovf = 0; m_und = 0;
    endtask

    task automatic test_random();
        int lat, elat, r, id; bit ok, eok;
        do_reset();
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                id = $urandom_range(0, 11);
                elat = exp_push_lat(id);
                eok = model_push(id);
                push_op(id, lat, ok);
            end else if (r < 9) begin
                elat = 1;
                eok = model_pop();
                pop_op(lat, ok);
            end else begin
                clear_err = 1'b1;
                @(negedge clk);
                clear_err = 1'b0;
                m_rec = 0; m_ovf = 0; m_und = 0;
                lat = 0; elat = 0; ok = 0; eok = 0;
            end
            checks++; if (lat !== elat || ok !== eok) begin errors++; $display("FAIL rnd_resp op %0d got lat %0d ok %b exp %0d %b", r, lat, ok, elat, eok); end
            checks++; if (depth !== 4'(q.size()) || top_id !== 4'(m_top())) begin errors++; $display("FAIL rnd_stack got depth %0d top %0d exp %0d %0d", depth, top_id, q.size(), m_top()); end
            checks++; if ({err_rec, err_ovf, err_und} !== {m_rec, m_ovf, m_und}) begin errors++; $display("FAIL rnd_flags got %b exp %b", {err_rec, err_ovf, err_und}, {m_rec, m_ovf, m_und}); end
        end
    endtask

    initial begin
        test_reset();
        test_push_seq();
        test_recursion();
        test_overflow();
        test_underflow_clear();
        test_simultaneous();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
